// File: rtl/addrmap_pkg.sv
// Shared types and encodings for the address_window_map decoder slice.
package addrmap_pkg;

   localparam int unsigned ADDRMAP_AW = 24;
   localparam int unsigned ATTR_W     = 4;

   localparam int unsigned ATTR_EN      = 0;
   localparam int unsigned ATTR_SRAM    = 1;
   localparam int unsigned ATTR_WR      = 2;
   localparam int unsigned ATTR_COMPACT = 3;

   typedef enum logic [2:0] {
      CFG_MATCH_MASK  = 3'd0,
      CFG_MATCH_VALUE = 3'd1,
      CFG_ADDR_MASK   = 3'd2,
      CFG_ADDR_OFFSET = 3'd3,
      CFG_ATTR        = 3'd4
   } cfg_field_t;

   typedef enum logic {
      CM_IDLE,
      CM_PENDING
   } commit_state_t;

   typedef struct packed {
      logic [ADDRMAP_AW-1:0] match_mask;
      logic [ADDRMAP_AW-1:0] match_value;
      logic [ADDRMAP_AW-1:0] addr_mask;
      logic [ADDRMAP_AW-1:0] addr_offset;
      logic [ATTR_W-1:0]     attr;
   } addrmap_win_t;

endpackage

// File: rtl/addrmap_window.sv
// One address window: hit compare plus pre-address squeeze and mask/offset translate.
module addrmap_window
   import addrmap_pkg::*;
#(
   parameter int unsigned AW = ADDRMAP_AW
)(
   input  logic [AW-1:0] addr,
   input  logic [AW-1:0] match_mask,
   input  logic [AW-1:0] match_value,
   input  logic [AW-1:0] addr_mask,
   input  logic [AW-1:0] addr_offset,
   input  logic          enable,
   input  logic          compact,
   output logic          hit,
   output logic [AW-1:0] xlat_addr
);

   logic [AW-1:0] pre_addr;

   always_comb begin
      hit = enable && ((addr & match_mask) == match_value);
      // compact drops A15 so 32 KiB LoROM banks pack contiguously
      if (compact) pre_addr = {1'b0, addr[AW-1:16], addr[14:0]};
      else         pre_addr = addr;
      xlat_addr = (pre_addr & addr_mask) | addr_offset;
   end

endmodule

// File: rtl/address_window_map.sv
// Registered NWIN-window SNES address decoder with double-buffered configuration.
// Optional sticky save-RAM dirty flag enabled by defining ADDRMAP_DIRTY_EN.
module address_window_map
   import addrmap_pkg::*;
#(
   parameter int unsigned NWIN = 4,
   parameter int unsigned AW   = ADDRMAP_AW
)(
   input  logic          CLK,
   input  logic          RST,
   input  logic [AW-1:0] SNES_ADDR,
   input  logic          SNES_ADDR_VALID,
   input  logic          SNES_WRITE,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_idx,
   input  logic [2:0]    cfg_field,
   input  logic [AW-1:0] cfg_data,
   input  logic          cfg_commit,
   output logic          commit_pending,
   output logic          OUT_VALID,
   output logic [AW-1:0] ROM_ADDR,
   output logic          ROM_HIT,
   output logic          IS_SAVERAM,
   output logic          IS_WRITABLE,
   output logic [3:0]    WIN_IDX,
   input  logic          dirty_clr,
   output logic          SAVERAM_DIRTY
);

   addrmap_win_t  shadow [NWIN];
   addrmap_win_t  active [NWIN];
   commit_state_t state_q, state_d;
   logic          do_copy;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < NWIN; i++) shadow[i] <= '0;
      end else if (cfg_we) begin
         for (int unsigned i = 0; i < NWIN; i++) begin
            if (32'(cfg_idx) == i) begin
               case (cfg_field)
                  CFG_MATCH_MASK:  shadow[i].match_mask  <= cfg_data;
                  CFG_MATCH_VALUE: shadow[i].match_value <= cfg_data;
                  CFG_ADDR_MASK:   shadow[i].addr_mask   <= cfg_data;
                  CFG_ADDR_OFFSET: shadow[i].addr_offset <= cfg_data;
                  CFG_ATTR:        shadow[i].attr        <= cfg_data[ATTR_W-1:0];
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= CM_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      do_copy = 1'b0;
      unique case (state_q)
         CM_IDLE:    if (cfg_commit) state_d = CM_PENDING;
         CM_PENDING: if (!SNES_ADDR_VALID) begin
            do_copy = 1'b1;
            state_d = CM_IDLE;
         end
         default:    state_d = CM_IDLE;
      endcase
   end

   assign commit_pending = (state_q == CM_PENDING);

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < NWIN; i++) active[i] <= '0;
      end else if (do_copy) begin
         for (int unsigned i = 0; i < NWIN; i++) active[i] <= shadow[i];
      end
   end

   logic [NWIN-1:0] win_hit;
   logic [AW-1:0]   win_xlat [NWIN];

   for (genvar g = 0; g < NWIN; g++) begin : g_win
      addrmap_window #(.AW(AW)) u_win (
         .addr        (SNES_ADDR),
         .match_mask  (active[g].match_mask),
         .match_value (active[g].match_value),
         .addr_mask   (active[g].addr_mask),
         .addr_offset (active[g].addr_offset),
         .enable      (active[g].attr[ATTR_EN]),
         .compact     (active[g].attr[ATTR_COMPACT]),
         .hit         (win_hit[g]),
         .xlat_addr   (win_xlat[g])
      );
   end

   logic            s1_valid;
   logic [NWIN-1:0] s1_hit;
   logic [AW-1:0]   s1_xlat [NWIN];

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid <= 1'b0;
         s1_hit   <= '0;
         for (int unsigned i = 0; i < NWIN; i++) s1_xlat[i] <= '0;
      end else begin
         s1_valid <= SNES_ADDR_VALID;
         s1_hit   <= win_hit;
         for (int unsigned i = 0; i < NWIN; i++) s1_xlat[i] <= win_xlat[i];
      end
   end

   // Attributes are read from the active set in stage 2: a copy needs an idle
   // input clock, so a valid stage-1 entry always sees the set it matched against.
   logic          sel_hit, sel_sram, sel_wr;
   logic [3:0]    sel_idx;
   logic [AW-1:0] sel_addr;

   always_comb begin
      sel_hit  = 1'b0;
      sel_sram = 1'b0;
      sel_wr   = 1'b0;
      sel_idx  = '0;
      sel_addr = '0;
      for (int unsigned i = 0; i < NWIN; i++) begin
         if (s1_hit[i] && !sel_hit) begin
            sel_hit  = 1'b1;
            sel_idx  = 4'(i);
            sel_addr = s1_xlat[i];
            sel_sram = active[i].attr[ATTR_SRAM];
            sel_wr   = active[i].attr[ATTR_WR];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID   <= 1'b0;
         ROM_ADDR    <= '0;
         ROM_HIT     <= 1'b0;
         IS_SAVERAM  <= 1'b0;
         IS_WRITABLE <= 1'b0;
         WIN_IDX     <= '0;
      end else begin
         OUT_VALID   <= s1_valid;
         ROM_ADDR    <= s1_valid ? sel_addr : '0;
         ROM_HIT     <= s1_valid & sel_hit;
         IS_SAVERAM  <= s1_valid & sel_sram;
         IS_WRITABLE <= s1_valid & sel_wr;
         WIN_IDX     <= s1_valid ? sel_idx : '0;
      end
   end

`ifdef ADDRMAP_DIRTY_EN
   logic s1_write;
   logic dirty_q;

   always_ff @(posedge CLK) begin
      if (RST) s1_write <= 1'b0;
      else     s1_write <= SNES_ADDR_VALID & SNES_WRITE;
   end

   // set term is computed from stage-1 data so the flag rises with the outputs
   always_ff @(posedge CLK) begin
      if (RST)                                dirty_q <= 1'b0;
      else if (s1_valid & sel_sram & s1_write) dirty_q <= 1'b1;
      else if (dirty_clr)                     dirty_q <= 1'b0;
   end

   assign SAVERAM_DIRTY = dirty_q;
`else
   logic unused_dirty_inputs;
   assign unused_dirty_inputs = ^{dirty_clr, SNES_WRITE};
   assign SAVERAM_DIRTY = 1'b0;
`endif

endmodule

// File: tb/tb_address_window_map.sv
// Directed self-checking bench for address_window_map (NWIN=4, AW=24).
module tb_address_window_map;

   localparam int unsigned NWIN = 4;
   localparam int unsigned AW   = 24;

`ifdef ADDRMAP_DIRTY_EN
   localparam logic [31:0] DIRTY_ON = 32'd1;
`else
   localparam logic [31:0] DIRTY_ON = 32'd0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [AW-1:0] SNES_ADDR = '0;
   logic          SNES_ADDR_VALID = 1'b0;
   logic          SNES_WRITE = 1'b0;
   logic          cfg_we = 1'b0;
   logic [3:0]    cfg_idx = '0;
   logic [2:0]    cfg_field = '0;
   logic [AW-1:0] cfg_data = '0;
   logic          cfg_commit = 1'b0;
   logic          commit_pending;
   logic          OUT_VALID;
   logic [AW-1:0] ROM_ADDR;
   logic          ROM_HIT;
   logic          IS_SAVERAM;
   logic          IS_WRITABLE;
   logic [3:0]    WIN_IDX;
   logic          dirty_clr = 1'b0;
   logic          SAVERAM_DIRTY;

   int n_pass  = 0;
   int n_total = 0;

   address_window_map #(.NWIN(NWIN), .AW(AW)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .SNES_ADDR       (SNES_ADDR),
      .SNES_ADDR_VALID (SNES_ADDR_VALID),
      .SNES_WRITE      (SNES_WRITE),
      .cfg_we          (cfg_we),
      .cfg_idx         (cfg_idx),
      .cfg_field       (cfg_field),
      .cfg_data        (cfg_data),
      .cfg_commit      (cfg_commit),
      .commit_pending  (commit_pending),
      .OUT_VALID       (OUT_VALID),
      .ROM_ADDR        (ROM_ADDR),
      .ROM_HIT         (ROM_HIT),
      .IS_SAVERAM      (IS_SAVERAM),
      .IS_WRITABLE     (IS_WRITABLE),
      .WIN_IDX         (WIN_IDX),
      .dirty_clr       (dirty_clr),
      .SAVERAM_DIRTY   (SAVERAM_DIRTY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic cfg_write(input logic [3:0] idx, input logic [2:0] fld, input logic [AW-1:0] data);
      cfg_we = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_data = data;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic set_window(input logic [3:0] idx, input logic [AW-1:0] mmask, input logic [AW-1:0] mval,
                             input logic [AW-1:0] amask, input logic [AW-1:0] aoff, input logic [AW-1:0] attr);
      cfg_write(idx, 3'd0, mmask);
      cfg_write(idx, 3'd1, mval);
      cfg_write(idx, 3'd2, amask);
      cfg_write(idx, 3'd3, aoff);
      cfg_write(idx, 3'd4, attr);
   endtask

   task automatic commit_idle();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      tick();
   endtask

   // Input sampled on the first edge, outputs observed after the second.
   task automatic decode(input string tag, input logic [AW-1:0] addr, input logic wr, input logic clr);
      SNES_ADDR = addr; SNES_ADDR_VALID = 1'b1; SNES_WRITE = wr;
      tick();
      chk({tag, "_latency"}, 32'(OUT_VALID), 0);
      SNES_ADDR_VALID = 1'b0; SNES_WRITE = 1'b0; dirty_clr = clr;
      tick();
      dirty_clr = 1'b0;
   endtask

   task automatic expect_dec(input string tag, input logic hit, input logic [AW-1:0] addr,
                             input logic sram, input logic wr, input logic [3:0] idx);
      chk({tag, "_valid"}, 32'(OUT_VALID),   1);
      chk({tag, "_hit"},   32'(ROM_HIT),     32'(hit));
      chk({tag, "_addr"},  32'(ROM_ADDR),    32'(addr));
      chk({tag, "_sram"},  32'(IS_SAVERAM),  32'(sram));
      chk({tag, "_wr"},    32'(IS_WRITABLE), 32'(wr));
      chk({tag, "_idx"},   32'(WIN_IDX),     32'(idx));
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      RST = 1'b0;
      tick();
      chk("rst_valid",   32'(OUT_VALID),      0);
      chk("rst_addr",    32'(ROM_ADDR),       0);
      chk("rst_hit",     32'(ROM_HIT),        0);
      chk("rst_idx",     32'(WIN_IDX),        0);
      chk("rst_pending", 32'(commit_pending), 0);
      chk("rst_dirty",   32'(SAVERAM_DIRTY),  0);

      // nothing configured: no hit
      decode("empty", 24'h808000, 1'b0, 1'b0);
      expect_dec("empty", 1'b0, 24'h000000, 1'b0, 1'b0, 4'd0);

      // window 0 LoROM compact; shadow alone must not affect decode
      set_window(4'd0, 24'h408000, 24'h008000, 24'h3FFFFF, 24'h000000, 24'h000009);
      decode("shadow_only", 24'h01C123, 1'b0, 1'b0);
      expect_dec("shadow_only", 1'b0, 24'h000000, 1'b0, 1'b0, 4'd0);
      commit_idle();
      chk("commit_done", 32'(commit_pending), 0);
      decode("lorom", 24'h01C123, 1'b0, 1'b0);
      expect_dec("lorom", 1'b1, 24'h00C123, 1'b0, 1'b0, 4'd0);
      tick();
      chk("idle_valid", 32'(OUT_VALID), 0);
      chk("idle_addr",  32'(ROM_ADDR),  0);

      // window 1 saveram+writable, window 0 disabled
      set_window(4'd1, 24'hF80000, 24'h700000, 24'h07FFFF, 24'hE00000, 24'h000007);
      cfg_write(4'd0, 3'd4, 24'h000000);
      commit_idle();
      decode("sram", 24'h712345, 1'b0, 1'b0);
      expect_dec("sram", 1'b1, 24'hE12345, 1'b1, 1'b1, 4'd1);

      // window 0 overlaps the same range and wins on priority
      set_window(4'd0, 24'hF80000, 24'h700000, 24'h00FFFF, 24'h100000, 24'h000001);
      commit_idle();
      decode("prio", 24'h712345, 1'b0, 1'b0);
      expect_dec("prio", 1'b1, 24'h102345, 1'b0, 1'b0, 4'd0);

      // commit deferred while the bus stays busy
      cfg_write(4'd0, 3'd3, 24'h200000);
      SNES_ADDR = 24'h712345; SNES_ADDR_VALID = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      chk("defer_pend1", 32'(commit_pending), 1);
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk($sformatf("defer_pend%0d", k), 32'(commit_pending), 1);
         chk($sformatf("defer_old%0d", k),  32'(ROM_ADDR), 'h102345);
      end
      SNES_ADDR_VALID = 1'b0;
      tick();
      chk("defer_clear", 32'(commit_pending), 0);
      decode("defer_new", 24'h712345, 1'b0, 1'b0);
      expect_dec("defer_new", 1'b1, 24'h202345, 1'b0, 1'b0, 4'd0);

      // out-of-range index and reserved field are ignored
      cfg_write(4'd4, 3'd3, 24'h300000);
      cfg_write(4'd0, 3'd6, 24'hFFFFFF);
      commit_idle();
      decode("ignored", 24'h712345, 1'b0, 1'b0);
      expect_dec("ignored", 1'b1, 24'h202345, 1'b0, 1'b0, 4'd0);
      decode("miss", 24'h01C123, 1'b0, 1'b0);
      expect_dec("miss", 1'b0, 24'h000000, 1'b0, 1'b0, 4'd0);

      // cfg_we together with cfg_commit is part of the commit
      cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 3'd3; cfg_data = 24'h300000; cfg_commit = 1'b1;
      tick();
      cfg_we = 1'b0; cfg_commit = 1'b0;
      tick();
      decode("same_cycle", 24'h712345, 1'b0, 1'b0);
      expect_dec("same_cycle", 1'b1, 24'h302345, 1'b0, 1'b0, 4'd0);

      // save-RAM dirty flag via window 1
      cfg_write(4'd0, 3'd4, 24'h000000);
      commit_idle();
      decode("dirty_wr", 24'h700010, 1'b1, 1'b0);
      expect_dec("dirty_wr", 1'b1, 24'hE00010, 1'b1, 1'b1, 4'd1);
      chk("dirty_set", 32'(SAVERAM_DIRTY), DIRTY_ON);
      decode("dirty_both", 24'h700020, 1'b1, 1'b1);
      chk("dirty_set_wins", 32'(SAVERAM_DIRTY), DIRTY_ON);
      dirty_clr = 1'b1;
      tick();
      dirty_clr = 1'b0;
      chk("dirty_cleared", 32'(SAVERAM_DIRTY), 0);
      decode("dirty_rd", 24'h700010, 1'b0, 1'b0);
      chk("dirty_read_only", 32'(SAVERAM_DIRTY), 0);

      // reset mid-commit and mid-pipeline discards everything
      SNES_ADDR = 24'h712345; SNES_ADDR_VALID = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0; SNES_ADDR_VALID = 1'b0; RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("mid_rst_pending", 32'(commit_pending), 0);
      chk("mid_rst_valid",   32'(OUT_VALID),      0);
      tick();
      chk("mid_rst_flushed", 32'(OUT_VALID), 0);
      decode("post_rst", 24'h712345, 1'b0, 1'b0);
      expect_dec("post_rst", 1'b0, 24'h000000, 1'b0, 1'b0, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/address_window_map.md
# address_window_map

Parametrised, registered successor to the fixed-mapper address decoder. It holds NWIN MCU-programmable address windows, each with a match pattern, a translation mask/offset and attributes. It resolves every SNES bus address to a ROM/SRAM address with hit and attribute flags through a two-stage pipeline. Window configuration is double-buffered: the MCU writes a shadow copy, and the shadow is committed atomically only while the SNES bus is idle. This lets mapper changes happen without tearing a decode in flight.

## Interface
Parameters:
- NWIN, 4: number of windows (1..16); lowest index has highest priority
- AW, 24: SNES and ROM address width

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- SNES_ADDR  in  AW  address to decode
- SNES_ADDR_VALID  in  1  SNES_ADDR is a live bus cycle this clock
- SNES_WRITE  in  1  current cycle is a write; qualified by SNES_ADDR_VALID
- cfg_we  in  1  write cfg_data into shadow window cfg_idx, field cfg_field
- cfg_idx  in  4  shadow window index; writes with cfg_idx >= NWIN are ignored
- cfg_field  in  3  field select: 0 match_mask, 1 match_value, 2 addr_mask, 3 addr_offset, 4 attr; 5..7 ignored
- cfg_data  in  AW  field value; attr uses bits [3:0]: enable, saveram, writable, compact
- cfg_commit  in  1  one-cycle pulse requesting shadow→active copy
- commit_pending  out  1  commit requested, not yet applied
- OUT_VALID  out  1  outputs below correspond to a valid input from 2 cycles earlier
- ROM_ADDR  out  AW  translated address
- ROM_HIT  out  1  some enabled window matched
- IS_SAVERAM  out  1  winning window has saveram attribute
- IS_WRITABLE  out  1  winning window has writable attribute
- WIN_IDX  out  4  index of winning window; 0 when no hit
- dirty_clr  in  1  clear SAVERAM_DIRTY
- SAVERAM_DIRTY  out  1  sticky: a write hit a saveram window

## Operation
- A window hits when its enable bit is set and `(SNES_ADDR & match_mask) == match_value`.
- Among hitting windows, the lowest index wins.
- Pre-address: if compact is set, use {1'b0, SNES_ADDR[23:16], SNES_ADDR[14:0]} (A15 squeezed out, LoROM style); otherwise use SNES_ADDR.
- ROM_ADDR = (pre & addr_mask) | addr_offset, truncated to AW. OR is used, not add; no carry.
- No hit: ROM_ADDR=0, ROM_HIT=IS_SAVERAM=IS_WRITABLE=0, WIN_IDX=0.
- Shadow writes never affect decode until they are committed.
- Commit:
  - cfg_commit sets commit_pending.
  - On the first clock with commit_pending=1 and SNES_ADDR_VALID=0, all shadow windows copy to active and commit_pending clears.
  - A cfg_we in the same cycle as cfg_commit is included in the commit.
  - A cfg_commit arriving while already pending is a no-op.
  - A cfg_we while pending is accepted and included if it lands before the copy cycle.
- Decodes already in the pipeline finish with the window set they were sampled against. Stage 1 registers the per-window hit vector and pre-address.

## Timing
- Latency: input valid at edge N produces outputs at edge N+2; throughput is one per clock.
- OUT_VALID is SNES_ADDR_VALID delayed by 2. When OUT_VALID=0, all decode outputs are forced to 0.
- The active copy occurs on an idle clock, so the next valid input decodes with the new windows.
- Reset values:
  - All outputs 0.
  - Shadow and active windows are all zero, so every enable is 0 and nothing hits.
  - commit_pending=0; pipeline flushed.
- RST asserted mid-commit or mid-pipeline discards everything; the first valid input after release yields OUT_VALID two cycles later with ROM_HIT=0.

## Configuration
- Macro ADDRMAP_DIRTY_EN.
- Defined:
  - SAVERAM_DIRTY sets when OUT_VALID & IS_SAVERAM & (SNES_WRITE delayed by 2).
  - dirty_clr clears it next edge; simultaneous set and clear gives set.
- Undefined: SAVERAM_DIRTY is tied 0, dirty_clr is ignored, and the write-delay pipeline is removed.

## Structure
- Package addrmap_pkg holds:
  - cfg_field encodings
  - attr bit positions (ATTR_EN=0, ATTR_SRAM=1, ATTR_WR=2, ATTR_COMPACT=3)
  - typedef addrmap_win_t containing match_mask, match_value, addr_mask, addr_offset, attr
- Sub-module addrmap_window: combinational hit compare plus pre-address/translate for one window, instanced NWIN times. Priority select and pipeline registers stay in the top module.

## Test plan
- Reset, then drive a valid input with address 0x808000 → at N+2 OUT_VALID=1, ROM_HIT=0, ROM_ADDR=0.
- Configure window 0: mask 0x408000, value 0x008000, compact, addr_mask 0x3FFFFF, offset 0, enable. Commit with the bus idle. Drive 0x01C123 → ROM_ADDR=0x00C123, WIN_IDX=0, ROM_HIT=1.
- Overlap priority: window 1 matches 0x700000–0x77FFFF as saveram+writable with offset 0xE00000, mask 0x07FFFF. Window 0 is disabled. Drive 0x712345 → ROM_ADDR=0xE12345, IS_SAVERAM=1, WIN_IDX=1. Enable window 0 covering the same range → WIN_IDX=0.
- Commit deferral: pulse cfg_commit while SNES_ADDR_VALID is held high for 5 cycles → commit_pending=1 throughout and old mapping used. First idle cycle → pending clears and the next decode uses the new mapping.
- Ignored writes: cfg_idx=NWIN or cfg_field=6, then commit → decode results identical to before.
- With ADDRMAP_DIRTY_EN: a write to 0x700010 in a saveram window sets SAVERAM_DIRTY at N+2. dirty_clr coincident with a new saveram write leaves it set; a lone dirty_clr clears it next cycle.
